clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of the half-period count and ratio fields.
REQ-002 Parameter DIV_RST, default 1, half-period count applied out of reset (half-period = DIV_RST+1 cycles).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rstb  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  run request; 1 = generate divided waveform, 0 = stop cleanly.
REQ-006 div_req  input  1  level request to load a new ratio; held until div_ack.
REQ-007 div_val  input  CNT_W  requested half-period count; stable while div_req=1.
REQ-008 div_ack  output  1  one-cycle pulse when the requested ratio is applied.
REQ-009 clkdat  output  1  registered divided-clock data, feeds the downstream clock flop data input.
REQ-010 active  output  1  1 while the state machine is in RUN or PEND or STOP.

Function
REQ-011 States: IDLE, RUN, PEND, STOP; encoding from the shared package.
REQ-012 IDLE: clkdat=0, cnt=0; en=1 -> RUN next cycle.
REQ-013 RUN: cnt increments each cycle; when cnt==ratio, clkdat toggles and cnt<=0 in the same edge.
REQ-014 Output period = 2*(ratio+1) cycles, duty 50%; ratio=0 gives clkdat toggling every cycle.
REQ-015 RUN with div_req=1 and div_ack=0 -> PEND; divided output continues unchanged.
REQ-016 PEND: new ratio loads only on the edge where clkdat goes 0->1 (end of low phase); that same edge pulses div_ack and returns to RUN.
REQ-017 div_ack is never asserted two consecutive cycles; a div_req still high the cycle after div_ack is not re-serviced until it drops for at least one cycle.
REQ-018 div_val sampled only on the loading edge; changes during PEND are taken at that edge.
REQ-019 en=0 in RUN or PEND -> STOP; a pending request is dropped without div_ack.
REQ-020 STOP: counting continues until the edge where clkdat goes 1->0 (or immediately if already 0 at the end of a low phase); then IDLE with clkdat=0, so no runt high pulse.
REQ-021 en=1 in STOP: finish STOP to IDLE first, then RUN; no re-entry mid-phase.
REQ-022 div_req in IDLE: ratio loads immediately with div_ack pulse next cycle (output is static low).
REQ-023 cnt is CNT_W wide, compares by equality, never exceeds ratio; no wrap beyond 2^CNT_W-1.

Reset
REQ-024 rstb low asynchronously forces: state=IDLE, clkdat=0, div_ack=0, active=0, cnt=0, ratio=DIV_RST.
REQ-025 Reset assertion mid-phase or mid-PEND discards all state; deassertion is synchronised externally; first active edge after release behaves as IDLE.

Configuration
REQ-026 Macro CLK_DIV_CTRL_STATUS_EN defined: adds output div_cur (CNT_W) = currently applied ratio, reset value DIV_RST, updates on the div_ack edge.
REQ-027 Macro undefined: div_cur port and its register absent; all other behaviour identical.

Structure
REQ-028 Shared package clk_div_pkg holds the state enum typedef and the default CNT_W/DIV_RST constants.
REQ-029 One sub-module clk_div_cnt: counter plus terminal-count compare (inputs ratio, run, clear; output tc); FSM and handshake stay in clk_div_ctrl.

Verification
REQ-030 Reset, en=1, ratio=DIV_RST=1 -> clkdat 0011 0011..., period 4 cycles, active=1 one cycle after en.
REQ-031 In RUN ratio=1, div_req with div_val=3 mid-high phase -> old period holds to next 0->1, div_ack one pulse there, then period 8.
REQ-032 div_val=0 -> clkdat toggles every cycle; div_val=255 -> period 512 cycles, cnt never exceeds 255.
REQ-033 en dropped during high phase, ratio=3 -> high phase completes to 4 cycles, clkdat=0 then IDLE, active=0; no pulse shorter than 4 cycles.
REQ-034 en dropped while in PEND -> no div_ack, ratio unchanged (div_cur keeps the old value under CLK_DIV_CTRL_STATUS_EN).
REQ-035 rstb asserted mid-high-phase -> clkdat=0 and div_ack=0 immediately without a clock edge; ratio returns to DIV_RST.

Source files
------------

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the clock-divider controller: the FSM state encoding
// and the default widths/reset ratio used by clk_div_ctrl and clk_div_cnt.
// No ports (package).
// -----------------------------------------------------------------------------
package clk_div_pkg;

  // Default width of the half-period counter and ratio fields.
  localparam int CNT_W_DEF   = 8;
  // Default half-period count applied out of reset (half-period = value+1).
  localparam int DIV_RST_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // output parked low, counter cleared
    ST_RUN  = 2'd1,  // free-running divided output
    ST_PEND = 2'd2,  // ratio change requested, waiting for end of low phase
    ST_STOP = 2'd3   // finishing the current high phase before parking
  } state_t;

endpackage : clk_div_pkg

// File: rtl/clk_div_cnt.sv
// -----------------------------------------------------------------------------
// clk_div_cnt
// Half-period counter with terminal-count compare. The count restarts at zero
// on the cycle after it matches the ratio, so it never exceeds the ratio.
//
// Ports:
//   clk    in   clock, rising edge
//   rstb   in   asynchronous active-low reset
//   ratio  in   [CNT_W] half-period count (terminal value)
//   run    in   advance the counter this cycle
//   clear  in   force the counter to zero (overrides run)
//   tc     out  count equals ratio this cycle
// -----------------------------------------------------------------------------
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [CNT_W-1:0] ratio,
  input  logic             run,
  input  logic             clear,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Equality compare: the ratio only changes while the count is zero, so the
  // count can never sit above the ratio and wrap.
  assign tc = (cnt == ratio);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule : clk_div_cnt

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Glitch-free programmable clock divider controller. Produces a registered
// 50%-duty divided clock data bit (period 2*(ratio+1) cycles), accepts ratio
// changes through a req/ack handshake that only lands at the end of a low
// phase, and stops cleanly without runt high pulses.
//
// Optional feature: define CLK_DIV_CTRL_STATUS_EN to add output div_cur
// (currently applied ratio).
//
// Ports:
//   clk      in   clock, rising edge
//   rstb     in   asynchronous active-low reset
//   en       in   run request (1 = divide, 0 = stop cleanly)
//   div_req  in   level request to load div_val, held until div_ack
//   div_val  in   [CNT_W] requested half-period count
//   div_ack  out  one-cycle pulse when the requested ratio is applied
//   clkdat   out  registered divided clock data
//   active   out  high while in RUN, PEND or STOP
//   div_cur  out  [CNT_W] applied ratio (only with CLK_DIV_CTRL_STATUS_EN)
// -----------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             div_req,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             clkdat,
  output logic             active
`ifdef CLK_DIV_CTRL_STATUS_EN
  ,
  output logic [CNT_W-1:0] div_cur
`endif
);

  state_t           state;
  logic [CNT_W-1:0] ratio;
  logic             req_hold;   // request already serviced, wait for it to drop
  logic             req_new;
  logic             tc;
  logic             cnt_run;
  logic             cnt_clear;

  // A request that was just acknowledged must go low for a cycle before it
  // can be serviced again, which also keeps div_ack from firing back-to-back.
  assign req_new   = div_req && !req_hold;

  // Counter is held at zero while parked, and when STOP exits from a low phase.
  assign cnt_run   = (state != ST_IDLE);
  assign cnt_clear = (state == ST_IDLE) || ((state == ST_STOP) && !clkdat);

  clk_div_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rstb  (rstb),
    .ratio (ratio),
    .run   (cnt_run),
    .clear (cnt_clear),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= ST_IDLE;
      clkdat   <= 1'b0;
      div_ack  <= 1'b0;
      active   <= 1'b0;
      ratio    <= CNT_W'(DIV_RST);
      req_hold <= 1'b0;
    end else begin
      // div_ack is a pulse: low unless a load happens on this edge.
      div_ack <= 1'b0;
      if (!div_req) begin
        req_hold <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          // Output is static low, so a new ratio can be applied at once.
          if (req_new) begin
            ratio    <= div_val;
            div_ack  <= 1'b1;
            req_hold <= 1'b1;
          end
          if (en) begin
            state  <= ST_RUN;
            active <= 1'b1;
          end
        end

        ST_RUN, ST_PEND: begin
          if (!en) begin
            // Keep the current phase going; STOP decides when to park. A
            // pending request is abandoned without an acknowledge.
            if (tc) clkdat <= !clkdat;
            state <= ST_STOP;
          end else if (state == ST_RUN) begin
            if (tc) clkdat <= !clkdat;
            if (req_new) state <= ST_PEND;
          end else if (!div_req) begin
            // Requester withdrew before the load point: just keep running.
            if (tc) clkdat <= !clkdat;
            state <= ST_RUN;
          end else if (tc && !clkdat) begin
            // End of a low phase: the new ratio starts with a full high phase.
            clkdat   <= 1'b1;
            ratio    <= div_val;
            div_ack  <= 1'b1;
            req_hold <= 1'b1;
            state    <= ST_RUN;
          end else begin
            if (tc) clkdat <= !clkdat;
          end
        end

        ST_STOP: begin
          // Park as soon as the output is low, or when the high phase ends,
          // so the last high pulse is always full length.
          if (!clkdat || tc) begin
            clkdat <= 1'b0;
            state  <= ST_IDLE;
            active <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_STATUS_EN
  // The ratio register already updates exactly on the acknowledge edge.
  assign div_cur = ratio;
`endif

endmodule : clk_div_ctrl

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl (CNT_W=8, DIV_RST=1). Expected output
// triples are queued before each clock and compared after it. Honours
// CLK_DIV_CTRL_STATUS_EN for the div_cur port.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

  logic       clk     = 1'b0;
  logic       rstb    = 1'b1;
  logic       en      = 1'b0;
  logic       div_req = 1'b0;
  logic [7:0] div_val = 8'd0;
  logic       div_ack;
  logic       clkdat;
  logic       active;
`ifdef CLK_DIV_CTRL_STATUS_EN
  logic [7:0] div_cur;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic clkdat;
    logic ack;
    logic active;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [7:0] val;     // ratio to load
    int         period;  // expected output period in cycles
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CNT_W   (8),
    .DIV_RST (1)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .en      (en),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .clkdat  (clkdat),
    .active  (active)
`ifdef CLK_DIV_CTRL_STATUS_EN
    ,
    .div_cur (div_cur)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected outputs for the coming edge, clock, then compare.
  task automatic cycle(input string nm, input logic c, input logic a, input logic act);
    exp_t e;
    e.clkdat = c;
    e.ack    = a;
    e.active = act;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    check({nm, " clkdat"}, 32'(clkdat), 32'(e.clkdat));
    check({nm, " ack"},    32'(div_ack), 32'(e.ack));
    check({nm, " active"}, 32'(active), 32'(e.active));
  endtask

  // Bounded wait for the controller to park; no acknowledge allowed meanwhile.
  task automatic wait_idle(input string nm, input int max);
    int n = 0;
    while (active !== 1'b0 && n < max) begin
      tick();
      n++;
      check({nm, " no_ack"}, 32'(div_ack), 32'd0);
    end
    check({nm, " parked"}, 32'(active), 32'd0);
    check({nm, " low"}, 32'(clkdat), 32'd0);
  endtask

  task automatic reset_dut();
    en      = 1'b0;
    div_req = 1'b0;
    rstb    = 1'b0;
    #2;
    rstb    = 1'b1;
  endtask

  initial begin
    vecs[0] = '{val: 8'd0,   period: 2};
    vecs[1] = '{val: 8'd2,   period: 6};
    vecs[2] = '{val: 8'd5,   period: 12};
    vecs[3] = '{val: 8'd255, period: 512};

    // Reset values, before and after a clock edge with reset held.
    #1 rstb = 1'b0;
    #1;
    check("rst clkdat", 32'(clkdat), 32'd0);
    check("rst ack",    32'(div_ack), 32'd0);
    check("rst active", 32'(active), 32'd0);
`ifdef CLK_DIV_CTRL_STATUS_EN
    check("rst div_cur", 32'(div_cur), 32'd1);
`endif
    tick();
    check("rst held clkdat", 32'(clkdat), 32'd0);
    rstb = 1'b1;

    // Default ratio 1: 0011 0011..., active one cycle after en.
    en = 1'b1;
    check("pre-run active", 32'(active), 32'd0);
    for (int j = 0; j < 12; j++) begin
      cycle("default", ((j / 2) % 2) == 1, 1'b0, 1'b1);
    end
    en = 1'b0;
    wait_idle("stop0", 50);

    // Table: load each ratio in IDLE, hold the request to show a single ack,
    // then run two full periods.
    foreach (vecs[i]) begin
      div_val = vecs[i].val;
      div_req = 1'b1;
      cycle("idle load", 1'b0, 1'b1, 1'b0);
      cycle("req held1", 1'b0, 1'b0, 1'b0);
      cycle("req held2", 1'b0, 1'b0, 1'b0);
      div_req = 1'b0;
      cycle("req drop",  1'b0, 1'b0, 1'b0);
`ifdef CLK_DIV_CTRL_STATUS_EN
      check("vec div_cur", 32'(div_cur), 32'(vecs[i].val));
`endif
      en = 1'b1;
      for (int j = 0; j < 2 * vecs[i].period; j++) begin
        cycle("vec run", (j % vecs[i].period) >= (vecs[i].period / 2), 1'b0, 1'b1);
      end
      en = 1'b0;
      wait_idle("vec stop", 600);
    end

    // Ratio change mid-high phase (div_val altered while pending), then en
    // dropped mid-high phase: the last high phase must still be 4 cycles.
    reset_dut();
    en = 1'b1;
    for (int j = 0; j < 22; j++) begin
      logic c;
      if (j < 6)       c = ((j / 2) % 2) == 1;
      else if (j < 18) c = (((j - 6) / 4) % 2) == 0;
      else             c = 1'b0;
      cycle("change", c, j == 6, j < 18);
      if (j == 2) begin
        div_req = 1'b1;
        div_val = 8'd2;
      end
      if (j == 4)  div_val = 8'd3;
      if (j == 6)  div_req = 1'b0;
      if (j == 15) en = 1'b0;
    end
`ifdef CLK_DIV_CTRL_STATUS_EN
    check("change div_cur", 32'(div_cur), 32'd3);
`endif

    // en dropped while pending, right before the would-be load edge.
    reset_dut();
    en = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cycle("pend", ((j / 2) % 2) == 1, 1'b0, 1'b1);
      if (j == 2) begin
        div_req = 1'b1;
        div_val = 8'd5;
      end
    end
    en = 1'b0;
    tick();
    check("pend drop ack", 32'(div_ack), 32'd0);
    div_req = 1'b0;
    wait_idle("pend stop", 20);
`ifdef CLK_DIV_CTRL_STATUS_EN
    check("pend div_cur", 32'(div_cur), 32'd1);
`endif
    en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      cycle("pend old ratio", ((j / 2) % 2) == 1, 1'b0, 1'b1);
    end

    // Asynchronous reset in a high phase restores the default ratio.
    reset_dut();
    div_val = 8'd6;
    div_req = 1'b1;
    cycle("ld6", 1'b0, 1'b1, 1'b0);
    div_req = 1'b0;
    en = 1'b1;
    for (int j = 0; j < 9; j++) begin
      cycle("ratio6", (j % 14) >= 7, 1'b0, 1'b1);
    end
    #1 rstb = 1'b0;
    #1;
    check("async clkdat", 32'(clkdat), 32'd0);
    check("async ack",    32'(div_ack), 32'd0);
    check("async active", 32'(active), 32'd0);
`ifdef CLK_DIV_CTRL_STATUS_EN
    check("async div_cur", 32'(div_cur), 32'd1);
`endif
    rstb = 1'b1;
    for (int j = 0; j < 8; j++) begin
      cycle("post rst", ((j / 2) % 2) == 1, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_clk_div_ctrl
